// File: rtl/recon_filter.sv
// rtl/recon_filter.sv - stereo boxcar / triangular reconstruction filter
//
// Takes one zero-stuffed stereo sample per valid/ready handshake. Each channel
// runs through two cascaded N-tap running sums: stage 1 gives a boxcar (ZOH)
// and stage 2 gives a triangular (linear-interp) response. Exactly one filtered
// stereo sample is emitted per accepted input.
//
// Ports:
//   CLOCK_50              system clock, rising edge
//   reset                 synchronous, active-high
//   in_valid / in_ready   input handshake; in_ready is high only in IDLE
//   left_in / right_in    signed input samples
//   rate_sel              001 -> N=2, 010 -> N=4, 100 -> N=8, other -> N=1
//   filt_mode             00 bypass, 01 boxcar, 10 triangular, 11 bypass
//   out_valid / out_ready output handshake; data held while stalled
//   left_out / right_out  saturated filtered samples
module recon_filter #(
  parameter int DATA_W   = 32,
  parameter int MAX_TAPS = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic [2:0]        rate_sel,
  input  logic [1:0]        filt_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out
);

  localparam int S1_W  = DATA_W + 3;
  localparam int S2_W  = DATA_W + 6;
  localparam int IDX_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_BOX    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  // Output range limits, sign-extended to the stage-2 width for comparison.
  localparam logic [S2_W-1:0] MAX_EXT = {7'b0000000, {(DATA_W-1){1'b1}}};
  localparam logic [S2_W-1:0] MIN_EXT = {7'b1111111, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, S1, S2, OUT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x_q    [2];
  logic [DATA_W-1:0] x_d    [2];
  // Latched config: shift = log2(N), mode normalised so 11 reads as 00.
  logic [1:0]        shift_q, shift_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] h1_q   [2][MAX_TAPS];
  logic [DATA_W-1:0] h1_d   [2][MAX_TAPS];
  logic [S1_W-1:0]   h2_q   [2][MAX_TAPS];
  logic [S1_W-1:0]   h2_d   [2][MAX_TAPS];
  logic [S1_W-1:0]   sum1_q [2];
  logic [S1_W-1:0]   sum1_d [2];
  logic [S2_W-1:0]   sum2_q [2];
  logic [S2_W-1:0]   sum2_d [2];
  logic [DATA_W-1:0] out_q  [2];
  logic [DATA_W-1:0] out_d  [2];

  logic [IDX_W-1:0]  tap;
  logic [1:0]        acc_shift;
  logic [1:0]        acc_mode;
  logic              cfg_change;

  function automatic logic [1:0] decode_shift(input logic [2:0] r);
    case (r)
      3'b001:  return 2'd1;
      3'b010:  return 2'd2;
      3'b100:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] decode_mode(input logic [1:0] m);
    case (m)
      MODE_BOX: return MODE_BOX;
      MODE_TRI: return MODE_TRI;
      default:  return MODE_BYPASS;
    endcase
  endfunction

  function automatic logic [S1_W-1:0] ext1(input logic [DATA_W-1:0] v);
    return {{3{v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [S2_W-1:0] ext2(input logic [S1_W-1:0] v);
    return {{3{v[S1_W-1]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic [S2_W-1:0] v);
    if ($signed(v) > $signed(MAX_EXT)) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if ($signed(v) < $signed(MIN_EXT)) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    sum1_d  = sum1_q;
    sum2_d  = sum2_q;
    out_d   = out_q;

    acc_shift  = decode_shift(rate_sel);
    acc_mode   = decode_mode(filt_mode);
    cfg_change = (acc_shift != shift_q) || (acc_mode != mode_q);
    // Index of the element that drops out of the N-wide window.
    tap        = IDX_W'((32'd1 << shift_q) - 32'd1);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d[0]  = left_in;
          x_d[1]  = right_in;
          shift_d = acc_shift;
          mode_d  = acc_mode;
          // A new config starts from an empty window; clearing on the accept
          // edge means S1 already sees zeroed history.
          if (cfg_change) begin
            for (int ch = 0; ch < 2; ch++) begin
              for (int i = 0; i < MAX_TAPS; i++) begin
                h1_d[ch][i] = '0;
                h2_d[ch][i] = '0;
              end
              sum1_d[ch] = '0;
              sum2_d[ch] = '0;
            end
          end
          state_d = S1;
        end
      end

      S1: begin
        for (int ch = 0; ch < 2; ch++) begin
          for (int i = MAX_TAPS - 1; i > 0; i--) begin
            h1_d[ch][i] = h1_q[ch][i-1];
          end
          h1_d[ch][0] = x_q[ch];
          sum1_d[ch]  = sum1_q[ch] + ext1(x_q[ch]) - ext1(h1_q[ch][tap]);
        end
        state_d = S2;
      end

      S2: begin
        for (int ch = 0; ch < 2; ch++) begin
          for (int i = MAX_TAPS - 1; i > 0; i--) begin
            h2_d[ch][i] = h2_q[ch][i-1];
          end
          h2_d[ch][0] = sum1_q[ch];
          sum2_d[ch]  = sum2_q[ch] + ext2(sum1_q[ch]) - ext2(h2_q[ch][tap]);
          case (mode_q)
            MODE_BOX: out_d[ch] = sat(ext2(sum1_q[ch]));
            // Arithmetic shift gives the divide-by-N rounded toward -inf.
            MODE_TRI: out_d[ch] = sat($signed(sum2_d[ch]) >>> shift_q);
            default:  out_d[ch] = x_q[ch];
          endcase
        end
        state_d = OUT;
      end

      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= 2'd0;
      mode_q  <= MODE_BYPASS;
      for (int ch = 0; ch < 2; ch++) begin
        x_q[ch]    <= '0;
        sum1_q[ch] <= '0;
        sum2_q[ch] <= '0;
        out_q[ch]  <= '0;
        for (int i = 0; i < MAX_TAPS; i++) begin
          h1_q[ch][i] <= '0;
          h2_q[ch][i] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      sum1_q  <= sum1_d;
      sum2_q  <= sum2_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign left_out  = out_q[0];
  assign right_out = out_q[1];

endmodule

// File: tb/tb_recon_filter.sv
// tb/tb_recon_filter.sv - scoreboard bench for recon_filter
module tb_recon_filter;

  logic        CLOCK_50;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] left_in;
  logic [31:0] right_in;
  logic [2:0]  rate_sel;
  logic [1:0]  filt_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] left_out;
  logic [31:0] right_out;

  logic        rand_ready;
  logic        rnd_ready;
  logic        ready_force;

  int          checks;
  int          errors;
  int          n_out;

  logic [63:0] exp_q [$];
  logic [63:0] exp_e;

  // Reference model: explicit sliding windows of the last N inputs and of the
  // last N stage-1 sums since the most recent flush.
  longint      hx [2][8];
  longint      hs [2][8];
  int          cfg_n;
  int          cfg_m;

  recon_filter #(.DATA_W(32), .MAX_TAPS(8)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .left_in   (left_in),
    .right_in  (right_in),
    .rate_sel  (rate_sel),
    .filt_mode (filt_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .left_out  (left_out),
    .right_out (right_out)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  assign out_ready = rand_ready ? rnd_ready : ready_force;

  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge CLOCK_50);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [31:0] sat32(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 8; i++) begin
        hx[c][i] = 0;
        hs[c][i] = 0;
      end
    end
    cfg_n = 1;
    cfg_m = 0;
  endtask

  task automatic model_push(input logic [31:0] l, input logic [31:0] r,
                            input logic [2:0] rs, input logic [1:0] fm);
    int          n;
    int          m;
    int          sh;
    longint      x;
    longint      s1;
    longint      s2;
    logic [31:0] o [2];
    case (rs)
      3'b001:  n = 2;
      3'b010:  n = 4;
      3'b100:  n = 8;
      default: n = 1;
    endcase
    m  = (fm == 2'b01) ? 1 : (fm == 2'b10) ? 2 : 0;
    sh = $clog2(n);
    if (n != cfg_n || m != cfg_m) begin
      model_reset();
      cfg_n = n;
      cfg_m = m;
    end
    for (int c = 0; c < 2; c++) begin
      x = (c == 0) ? longint'($signed(l)) : longint'($signed(r));
      for (int i = 7; i > 0; i--) hx[c][i] = hx[c][i-1];
      hx[c][0] = x;
      s1 = 0;
      for (int i = 0; i < n; i++) s1 += hx[c][i];
      for (int i = 7; i > 0; i--) hs[c][i] = hs[c][i-1];
      hs[c][0] = s1;
      s2 = 0;
      for (int i = 0; i < n; i++) s2 += hs[c][i];
      case (m)
        1:       o[c] = sat32(s1);
        2:       o[c] = sat32(s2 >>> sh);
        default: o[c] = sat32(x);
      endcase
    end
    exp_q.push_back({o[0], o[1]});
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rise.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!reset && out_valid && out_ready) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output L=%h R=%h with empty scoreboard", left_out, right_out);
        end else begin
          exp_e = exp_q.pop_front();
          if ({left_out, right_out} !== exp_e) begin
            errors++;
            $display("FAIL scoreboard got L=%h R=%h required L=%h R=%h",
                     left_out, right_out, exp_e[63:32], exp_e[31:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r,
                      input logic [2:0] rs, input logic [1:0] fm);
    int b;
    left_in   = l;
    right_in  = r;
    rate_sel  = rs;
    filt_mode = fm;
    in_valid  = 1'b1;
    b = 0;
    @(negedge CLOCK_50);
    while (!in_ready && b < 200) begin
      @(negedge CLOCK_50);
      b++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
    end else begin
      model_push(l, r, rs, fm);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || !in_ready) && b < 300) begin
      @(negedge CLOCK_50);
      b++;
    end
    checks++;
    if (exp_q.size() != 0 || !in_ready) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_l;
    logic [31:0] hold_r;
    logic [31:0] d;
    logic [2:0]  rs;
    logic [1:0]  fm;
    logic [2:0]  rs_tab [6];
    int          n_before;
    int          sel;

    checks = 0;
    errors = 0;
    n_out  = 0;
    rs_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b111};
    reset       = 1'b1;
    in_valid    = 1'b0;
    left_in     = '0;
    right_in    = '0;
    rate_sel    = '0;
    filt_mode   = '0;
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_left_out", left_out, 32'd0);
    check("reset_right_out", right_out, 32'd0);
    tick();

    // Bypass N=1: latency and in_ready timing.
    send(32'h0000_1234, 32'hFFFF_FF00, 3'b000, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLOCK_50);
      check($sformatf("lat_in_ready_t%0d", k), {31'd0, in_ready}, 32'd0);
      check($sformatf("lat_out_valid_t%0d", k), {31'd0, out_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    wait_idle();

    // Boxcar N=4 on zero-stuffed input.
    for (int k = 0; k < 8; k++) begin
      d = (k == 0) ? 32'd100 : (k == 4) ? -32'sd50 : 32'd0;
      send(d, -d, 3'b010, 2'b01);
    end
    wait_idle();

    // Triangular N=2.
    for (int k = 0; k < 5; k++) begin
      d = (k % 2 == 0) ? 32'd8 : 32'd0;
      send(d, d, 3'b001, 2'b10);
    end
    wait_idle();

    // Boxcar N=8 saturation at both rails.
    for (int k = 0; k < 8; k++) send(32'h7FFF_FFFF, 32'h8000_0000, 3'b100, 2'b01);
    for (int k = 0; k < 8; k++) send(32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 2'b01);
    wait_idle();

    // Rate change mid-stream flushes history.
    send(32'd100, 32'd200, 3'b010, 2'b01);
    send(32'd0, 32'd0, 3'b010, 2'b01);
    send(32'd0, 32'd0, 3'b010, 2'b01);
    send(32'd7, -32'sd9, 3'b100, 2'b01);
    send(32'd0, 32'd0, 3'b100, 2'b01);
    wait_idle();

    // Backpressure with a waiting upstream sample.
    ready_force = 1'b0;
    send(32'h0000_0ABC, 32'hFFFF_F000, 3'b000, 2'b00);
    left_in  = 32'h1111_1111;
    right_in = 32'h2222_2222;
    in_valid = 1'b1;
    n_before = n_out;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK_50);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      if (k == 0) begin
        hold_l = left_out;
        hold_r = right_out;
      end else begin
        check("bp_left_stable", left_out, hold_l);
        check("bp_right_stable", right_out, hold_r);
      end
    end
    tick();
    ready_force = 1'b1;
    in_valid    = 1'b0;
    repeat (5) tick();
    check("bp_single_output", n_out, n_before + 1);
    wait_idle();

    // Reset while the sample is in S1: no output for it.
    send(32'h0000_0055, 32'h0000_0066, 3'b010, 2'b01);
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLOCK_50);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_left_out", left_out, 32'd0);
      check("rst_right_out", right_out, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    end
    tick();

    // Randomised traffic with random output backpressure.
    rand_ready = 1'b1;
    for (int blk = 0; blk < 30; blk++) begin
      rs = rs_tab[$urandom_range(0, 5)];
      fm = 2'($urandom_range(0, 3));
      for (int k = 0; k < 10; k++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0:       d = 32'd0;
          1:       d = $urandom;
          2:       d = 32'($urandom_range(0, 2000)) - 32'd1000;
          default: d = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
        hold_r = (sel == 1) ? $urandom : -d;
        send(d, hold_r, rs, fm);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    wait_idle();
    rand_ready = 1'b0;

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
